// File: rtl/m706.sv
`default_nettype none
// ============================================================================
// Module   : m706
// Purpose  : Asynchronous serial teletype receiver driven by the m452 8x-baud
//            square wave; optional 2-of-3 vote per bit via M706_MAJORITY_EN.
// Revision : 1.0
// ============================================================================
module m706 #(
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_8x,
    input  logic       serial_in,
    input  logic       flag_clr,
    output logic [7:0] data,
    output logic       flag,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_START     = 3'd1;
    localparam logic [2:0] c_ST_DATA      = 3'd2;
    localparam logic [2:0] c_ST_STOP      = 3'd3;
    localparam logic [2:0] c_ST_WAIT_MARK = 3'd4;

    localparam int         c_ALIGN    = 8 - DATA_BITS;
    localparam logic [2:0] c_LAST_BIT = 3'(DATA_BITS - 1);

    // Phase values (before increment) at which a bit is decided, and the
    // phase reloaded on start acceptance so data centres land on wrap.
`ifdef M706_MAJORITY_EN
    localparam logic [2:0] c_START_DEC    = 3'd4;
    localparam logic [2:0] c_BIT_DEC      = 3'd0;
    localparam logic [2:0] c_START_RELOAD = 3'd1;
`else
    localparam logic [2:0] c_START_DEC    = 3'd3;
    localparam logic [2:0] c_BIT_DEC      = 3'd7;
    localparam logic [2:0] c_START_RELOAD = 3'd0;
`endif

    logic       r_rx_meta, r_rx;
    logic       r_tk_meta, r_tk_sync, r_tk_prev, r_tick;
    logic [2:0] r_state;
    logic [2:0] r_phase;
    logic [2:0] r_bitcnt;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_flag, r_ferr, r_overrun;
    logic       w_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx      <= 1'b1;
            r_tk_meta <= 1'b0;
            r_tk_sync <= 1'b0;
            r_tk_prev <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_rx_meta <= serial_in;
            r_rx      <= r_rx_meta;
            r_tk_meta <= tick_8x;
            r_tk_sync <= r_tk_meta;
            r_tk_prev <= r_tk_sync;
            r_tick    <= r_tk_sync & ~r_tk_prev;
        end
    end

`ifdef M706_MAJORITY_EN
    // Two-deep history of rx at consecutive ticks; at centre+1 these hold
    // the centre-1 and centre samples.
    logic r_v0, r_v1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v0 <= 1'b1;
            r_v1 <= 1'b1;
        end else if (r_tick) begin
            r_v0 <= r_v1;
            r_v1 <= r_rx;
        end
    end

    assign w_bit = (r_v0 & r_v1) | (r_v0 & r_rx) | (r_v1 & r_rx);
`else
    assign w_bit = r_rx;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_phase   <= 3'd0;
            r_bitcnt  <= 3'd0;
            r_shift   <= 8'd0;
            r_data    <= 8'd0;
            r_flag    <= 1'b0;
            r_ferr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (flag_clr) begin
                r_flag    <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (r_tick) begin
                r_phase <= r_phase + 3'd1;
                case (r_state)
                    c_ST_IDLE: begin
                        r_phase <= 3'd0;
                        if (!r_rx) r_state <= c_ST_START;
                    end
                    c_ST_START: begin
                        if (r_phase == c_START_DEC) begin
                            if (w_bit) begin
                                r_state <= c_ST_IDLE;
                            end else begin
                                r_phase  <= c_START_RELOAD;
                                r_bitcnt <= 3'd0;
                                r_state  <= c_ST_DATA;
                            end
                        end
                    end
                    c_ST_DATA: begin
                        if (r_phase == c_BIT_DEC) begin
                            r_shift  <= {w_bit, r_shift[7:1]};
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == c_LAST_BIT) r_state <= c_ST_STOP;
                        end
                    end
                    c_ST_STOP: begin
                        if (r_phase == c_BIT_DEC) begin
                            // Load overrides a coincident flag_clr.
                            r_data <= r_shift >> c_ALIGN;
                            r_flag <= 1'b1;
                            r_ferr <= ~w_bit;
                            if (r_flag && !flag_clr) r_overrun <= 1'b1;
                            r_state <= w_bit ? c_ST_IDLE : c_ST_WAIT_MARK;
                        end
                    end
                    c_ST_WAIT_MARK: begin
                        if (r_rx) r_state <= c_ST_IDLE;
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign data        = r_data;
    assign flag        = r_flag;
    assign framing_err = r_ferr;
    assign overrun     = r_overrun;
    assign busy        = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_m706.sv
`default_nettype none
// ============================================================================
// Module   : tb_m706
// Purpose  : Scoreboard bench for the m706 serial receiver.
// Revision : 1.0
// ============================================================================
module tb_m706;

`ifdef M706_MAJORITY_EN
    localparam int         c_LOAD_TICK  = 77;
    localparam logic [7:0] c_GLITCH_EXP = 8'h0F;
`else
    localparam int         c_LOAD_TICK  = 76;
    localparam logic [7:0] c_GLITCH_EXP = 8'hF0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_8x = 1'b0;
    logic       serial_in = 1'b1;
    logic       flag_clr = 1'b0;
    logic [7:0] data;
    logic       flag, framing_err, overrun, busy;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    logic       prev_reset = 1'b1;
    logic       prev_flag  = 1'b0;
    logic [7:0] prev_data  = 8'd0;

    m706 #(.DATA_BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_8x     (tick_8x),
        .serial_in   (serial_in),
        .flag_clr    (flag_clr),
        .data        (data),
        .flag        (flag),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // A character is produced when flag rises or data changes outside reset.
    always @(negedge clk) begin
        if (!reset && !prev_reset && ((flag && !prev_flag) || (data != prev_data))) begin
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ld_data", data, e.d);
                check("ld_ferr", framing_err, e.fe);
                check("ld_ovr", overrun, e.ov);
                check("ld_flag", flag, 1);
            end
        end
        prev_reset <= reset;
        prev_flag  <= flag;
        prev_data  <= data;
    end

    // One 8x tick with the line at v; optional flag_clr in the tick's action cycle.
    task automatic tick_line(input logic v, input logic clr);
        serial_in = v;
        repeat (3) @(posedge clk);
        #1;
        tick_8x = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        flag_clr = clr;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        tick_8x  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick_line(1'b1, 1'b0);
    endtask

    task automatic pulse_clr();
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
    endtask

    // Frame: start, 8 data bits LSB first, stop, then extra low ticks.
    task automatic send_char(input logic [7:0] ch, input bit glitch, input bit stop_low,
                             input int extra_low, input bit clr_at_load, input int abort_at);
        logic lv;
        for (int t = 0; t < 80 + extra_low; t++) begin
            if (t == abort_at) return;
            if (t < 8) lv = 1'b0;
            else if (t < 72) begin
                lv = ch[(t - 8) / 8];
                if (glitch && ((t - 8) % 8 == 4)) lv = ~lv;
            end else if (t < 80) lv = ~stop_low;
            else lv = 1'b0;
            tick_line(lv, clr_at_load && (t == c_LOAD_TICK));
            if (t == c_LOAD_TICK - 1) check("busy_pre_stop", busy, 1);
            if (t == c_LOAD_TICK) check("busy_post_stop", busy, stop_low);
        end
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("rst_data", data, 0);
        check("rst_flag", flag, 0);
        check("rst_ferr", framing_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        idle_ticks(3);

        // Normal 8N1 frame
        sb.push_back('{8'h55, 1'b0, 1'b0});
        send_char(8'h55, 0, 0, 0, 0, -1);
        idle_ticks(2);
        pulse_clr();
        check("clr_flag", flag, 0);

        // False start
        tick_line(1'b0, 1'b0);
        check("fs_busy_up", busy, 1);
        tick_line(1'b0, 1'b0);
        idle_ticks(8);
        check("fs_busy_down", busy, 0);
        check("fs_flag", flag, 0);
        check("fs_data", data, 8'h55);

        // Break: one character, then WAIT_MARK until the line returns to mark
        sb.push_back('{8'h00, 1'b1, 1'b0});
        send_char(8'h00, 0, 1, 30, 0, -1);
        check("brk_busy_hold", busy, 1);
        check("brk_flag", flag, 1);
        idle_ticks(2);
        check("brk_busy_down", busy, 0);
        pulse_clr();
        sb.push_back('{8'h41, 1'b0, 1'b0});
        send_char(8'h41, 0, 0, 0, 0, -1);
        idle_ticks(2);
        pulse_clr();

        // Overrun
        sb.push_back('{8'h31, 1'b0, 1'b0});
        send_char(8'h31, 0, 0, 0, 0, -1);
        idle_ticks(1);
        sb.push_back('{8'h32, 1'b0, 1'b1});
        send_char(8'h32, 0, 0, 0, 0, -1);
        idle_ticks(1);
        pulse_clr();
        check("ovr_clr_flag", flag, 0);
        check("ovr_clr_ovr", overrun, 0);
        check("ovr_clr_data", data, 8'h32);

        // Load collides with flag_clr
        sb.push_back('{8'h33, 1'b0, 1'b0});
        send_char(8'h33, 0, 0, 0, 0, -1);
        idle_ticks(1);
        sb.push_back('{8'h34, 1'b0, 1'b0});
        send_char(8'h34, 0, 0, 0, 1, -1);
        idle_ticks(1);
        check("col_flag", flag, 1);
        check("col_ovr", overrun, 0);

        // Reset mid-frame
        send_char(8'h5A, 0, 0, 0, 0, 40);
        serial_in = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_data", data, 0);
        check("mid_rst_flag", flag, 0);
        check("mid_rst_ferr", framing_err, 0);
        check("mid_rst_ovr", overrun, 0);
        check("mid_rst_busy", busy, 0);
        idle_ticks(3);
        check("mid_rst_idle", busy, 0);

        // Glitch at every data-bit centre
        sb.push_back('{c_GLITCH_EXP, 1'b0, 1'b0});
        send_char(8'h0F, 1, 0, 0, 0, -1);
        idle_ticks(2);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
